sim_result_checker: RTL and testbench

SIM_RESULT_CHECKER -- requirements
Module: sim_result_checker

---
 rtl/sim_chk_pkg.sv | 25 ++
 rtl/sim_chk_watchdog.sv | 25 ++
 rtl/sim_result_checker.sv | 144 ++++++++++++++
 tb/tb_sim_result_checker.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_chk_pkg.sv
// Shared types and default constants for the simulation result checker.
// Mismatch records are sized for the widest supported port (32-bit address, 64-bit data).
package sim_chk_pkg;

   typedef enum logic [1:0] {
      WAIT_END = 2'd0,
      SWEEP    = 2'd1,
      DRAIN    = 2'd2,
      FINISH   = 2'd3
   } state_t;

   localparam int          DEF_END_ADDR    = 'h3fff;
   localparam logic [63:0] DEF_END_CODE    = '1;
   localparam int          DEF_TIMEOUT_CYC = 300000;

   localparam int REC_ADDR_W = 32;
   localparam int REC_DATA_W = 64;

   typedef struct packed {
      logic [REC_ADDR_W-1:0] addr;
      logic [REC_DATA_W-1:0] got;
      logic [REC_DATA_W-1:0] exp;
   } mis_rec_t;

endpackage

// File: rtl/sim_chk_watchdog.sv
// Cycle watchdog: expired is high during the LIMIT-th enabled cycle after reset.
module sim_chk_watchdog #(
   parameter int LIMIT = 300000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;

   assign expired = en && (cnt == CW'(LIMIT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/sim_result_checker.sv
// Polls memory for an end marker, then compares a block of data memory against a
// golden ROM and reports per-word mismatches plus sticky done/pass/timeout status.
module sim_result_checker
   import sim_chk_pkg::*;
#(
   parameter int                ADDR_W      = 14,
   parameter int                DATA_W      = 32,
   parameter int                MAX_WORDS   = 64,
   parameter logic [ADDR_W-1:0] END_ADDR    = ADDR_W'(DEF_END_ADDR),
   parameter logic [DATA_W-1:0] END_CODE    = DATA_W'(DEF_END_CODE),
   parameter logic [ADDR_W-1:0] TEST_START  = '0,
   parameter int                TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   localparam int               CNT_W       = $clog2(MAX_WORDS + 1),
   localparam int               GA_W        = $clog2(MAX_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CNT_W-1:0]  num_words,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              gold_re,
   output logic [GA_W-1:0]   gold_addr,
   input  logic [DATA_W-1:0] gold_rdata,
   output logic              mis_valid,
   output logic [ADDR_W-1:0] mis_addr,
   output logic [DATA_W-1:0] mis_got,
   output logic [DATA_W-1:0] mis_exp,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [CNT_W-1:0]  err_cnt
);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  n_words, idx, err_nxt;
   logic              expired, end_hit, mis_p1;
   logic              poll_vld_p1, vld_p1;
   logic [ADDR_W-1:0] addr_p1;
   mis_rec_t          rec;
   logic              rec_unused;

   function automatic logic [CNT_W-1:0] clip_words(input logic [CNT_W-1:0] n);
      return (n > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : n;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_W'(MAX_WORDS)) ? v : v + CNT_W'(1);
   endfunction

   sim_chk_watchdog #(.LIMIT(TIMEOUT_CYC)) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .en      (state == WAIT_END),
      .expired (expired)
   );

   // Stage p1: poll result and sweep compare, one cycle behind the read request
   assign end_hit = (state == WAIT_END) && poll_vld_p1 && (mem_rdata === END_CODE);
   assign mis_p1  = vld_p1 && (mem_rdata !== gold_rdata);
   assign err_nxt = mis_p1 ? sat_inc(err_cnt) : err_cnt;

   always_comb begin
      state_nxt = state;
      mem_re    = 1'b0;
      mem_addr  = '0;
      gold_re   = 1'b0;
      gold_addr = '0;
      case (state)
         WAIT_END: begin
            mem_re   = 1'b1;
            mem_addr = END_ADDR;
            if (end_hit || expired) state_nxt = SWEEP;
         end
         SWEEP: begin
            if (n_words == '0) begin
               state_nxt = FINISH;
            end else begin
               mem_re    = 1'b1;
               gold_re   = 1'b1;
               mem_addr  = TEST_START + ADDR_W'(idx);
               gold_addr = idx[GA_W-1:0];
               if (idx == n_words - CNT_W'(1)) state_nxt = DRAIN;
            end
         end
         DRAIN:   state_nxt = FINISH;
         FINISH:  state_nxt = FINISH;
         default: state_nxt = WAIT_END;
      endcase
      // Requests stay quiet while reset is held so the first poll follows its release.
      if (rst) begin
         mem_re    = 1'b0;
         mem_addr  = '0;
         gold_re   = 1'b0;
         gold_addr = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= WAIT_END;
         n_words     <= '0;
         idx         <= '0;
         poll_vld_p1 <= 1'b0;
         vld_p1      <= 1'b0;
         addr_p1     <= '0;
         err_cnt     <= '0;
         mis_valid   <= 1'b0;
         rec         <= '0;
         done        <= 1'b0;
         pass        <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_nxt;
         poll_vld_p1 <= mem_re && (state == WAIT_END);
         vld_p1      <= gold_re;
         addr_p1     <= mem_addr;
         err_cnt     <= err_nxt;
         mis_valid   <= mis_p1;
         if (mis_p1) begin
            rec.addr <= REC_ADDR_W'(addr_p1);
            rec.got  <= REC_DATA_W'(mem_rdata);
            rec.exp  <= REC_DATA_W'(gold_rdata);
         end
         if (state == WAIT_END && state_nxt == SWEEP) begin
            n_words <= clip_words(num_words);
            idx     <= '0;
            if (!end_hit) timeout <= 1'b1;
         end
         if (gold_re) idx <= idx + CNT_W'(1);
         // The drain-cycle compare lands on the same edge, hence err_nxt.
         if (state_nxt == FINISH && state != FINISH) begin
            done <= 1'b1;
            pass <= (err_nxt == '0) && !timeout;
         end
      end
   end

   assign mis_addr   = rec.addr[ADDR_W-1:0];
   assign mis_got    = rec.got[DATA_W-1:0];
   assign mis_exp    = rec.exp[DATA_W-1:0];
   assign rec_unused = ^rec;

endmodule

// File: tb/tb_sim_result_checker.sv
// Directed bench: one checker with default parameters (A) and one with a short
// watchdog and a sweep start near the top of memory (B).
module tb_sim_result_checker;

   localparam int AW = 14;
   localparam int DW = 32;
   localparam int MW = 64;
   localparam int CW = 7;
   localparam int GW = 6;
   localparam logic [AW-1:0] END_A = 14'h3fff;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_a, rst_b;
   logic [CW-1:0] num_words_a, num_words_b;
   logic          mem_re_a, mem_re_b, gold_re_a, gold_re_b;
   logic [AW-1:0] mem_addr_a, mem_addr_b, mis_addr_a, mis_addr_b;
   logic [GW-1:0] gold_addr_a, gold_addr_b;
   logic [DW-1:0] mem_rdata_a, mem_rdata_b, gold_rdata_a, gold_rdata_b;
   logic [DW-1:0] mis_got_a, mis_got_b, mis_exp_a, mis_exp_b;
   logic          mis_valid_a, mis_valid_b, done_a, done_b;
   logic          pass_a, pass_b, timeout_a, timeout_b;
   logic [CW-1:0] err_cnt_a, err_cnt_b;

   logic [DW-1:0] mem_a [0:(1<<AW)-1];
   logic [DW-1:0] mem_b [0:(1<<AW)-1];
   logic [DW-1:0] gold  [0:MW-1];

   sim_result_checker u_a (
      .clk(clk), .rst(rst_a), .num_words(num_words_a),
      .mem_re(mem_re_a), .mem_addr(mem_addr_a), .mem_rdata(mem_rdata_a),
      .gold_re(gold_re_a), .gold_addr(gold_addr_a), .gold_rdata(gold_rdata_a),
      .mis_valid(mis_valid_a), .mis_addr(mis_addr_a), .mis_got(mis_got_a), .mis_exp(mis_exp_a),
      .done(done_a), .pass(pass_a), .timeout(timeout_a), .err_cnt(err_cnt_a)
   );

   sim_result_checker #(.TIMEOUT_CYC(50), .TEST_START(14'h3ffe)) u_b (
      .clk(clk), .rst(rst_b), .num_words(num_words_b),
      .mem_re(mem_re_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b),
      .gold_re(gold_re_b), .gold_addr(gold_addr_b), .gold_rdata(gold_rdata_b),
      .mis_valid(mis_valid_b), .mis_addr(mis_addr_b), .mis_got(mis_got_b), .mis_exp(mis_exp_b),
      .done(done_b), .pass(pass_b), .timeout(timeout_b), .err_cnt(err_cnt_b)
   );

   // One-cycle-latency memory and golden ROM models
   always @(posedge clk) begin
      if (mem_re_a)  mem_rdata_a  <= mem_a[mem_addr_a];
      if (mem_re_b)  mem_rdata_b  <= mem_b[mem_addr_b];
      if (gold_re_a) gold_rdata_a <= gold[gold_addr_a];
      if (gold_re_b) gold_rdata_b <= gold[gold_addr_b];
   end

   int sel;
   logic          v_mem_re, v_gold_re, v_mis_valid, v_done, v_pass, v_timeout;
   logic [AW-1:0] v_mem_addr, v_mis_addr;
   logic [GW-1:0] v_gold_addr;
   logic [DW-1:0] v_mis_got, v_mis_exp;
   logic [CW-1:0] v_err_cnt;

   assign v_mem_re    = (sel != 0) ? mem_re_b    : mem_re_a;
   assign v_mem_addr  = (sel != 0) ? mem_addr_b  : mem_addr_a;
   assign v_gold_re   = (sel != 0) ? gold_re_b   : gold_re_a;
   assign v_gold_addr = (sel != 0) ? gold_addr_b : gold_addr_a;
   assign v_mis_valid = (sel != 0) ? mis_valid_b : mis_valid_a;
   assign v_mis_addr  = (sel != 0) ? mis_addr_b  : mis_addr_a;
   assign v_mis_got   = (sel != 0) ? mis_got_b   : mis_got_a;
   assign v_mis_exp   = (sel != 0) ? mis_exp_b   : mis_exp_a;
   assign v_done      = (sel != 0) ? done_b      : done_a;
   assign v_pass      = (sel != 0) ? pass_b      : pass_a;
   assign v_timeout   = (sel != 0) ? timeout_b   : timeout_a;
   assign v_err_cnt   = (sel != 0) ? err_cnt_b   : err_cnt_a;

   int tests = 0;
   int fails = 0;

   int            c, gold_cnt, mis_cnt, first_gold, done_cyc, to_cyc, naddr;
   logic [AW-1:0] addrs [0:7];
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_got, m_exp;
   bit            fin;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input int s);
      sel = s;
      if (s == 0) rst_a = 1'b1; else rst_b = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_re",    v_mem_re, 0);
      check("rst_gold_re",   v_gold_re, 0);
      check("rst_mem_addr",  v_mem_addr, 0);
      check("rst_done",      v_done, 0);
      check("rst_pass",      v_pass, 0);
      check("rst_timeout",   v_timeout, 0);
      check("rst_err_cnt",   v_err_cnt, 0);
      check("rst_mis_valid", v_mis_valid, 0);
      if (s == 0) rst_a = 1'b0; else rst_b = 1'b0;
      #1;
      check("first_poll_re",   v_mem_re, 1);
      check("first_poll_addr", v_mem_addr, END_A);
   endtask

   // Steps cycle by cycle from cycle 0 (first cycle after reset release), logging events.
   task automatic run(input int end_at, input int max_cyc, input int stop_gold);
      c = 0; gold_cnt = 0; mis_cnt = 0; first_gold = -1; done_cyc = -1; to_cyc = -1;
      naddr = 0; fin = 1'b0;
      while (!fin && c < max_cyc) begin
         if (v_gold_re) begin
            if (first_gold < 0) first_gold = c;
            if (naddr < 8) addrs[naddr] = v_mem_addr;
            naddr++;
            gold_cnt++;
         end
         if (v_mis_valid) begin
            mis_cnt++;
            m_addr = v_mis_addr;
            m_got  = v_mis_got;
            m_exp  = v_mis_exp;
         end
         if (v_timeout && to_cyc < 0) to_cyc = c;
         if (v_done) begin
            done_cyc = c;
            fin = 1'b1;
         end else if (stop_gold > 0 && gold_cnt == stop_gold) begin
            fin = 1'b1;
         end else begin
            if (c == end_at) begin
               if (sel == 0) mem_a[END_A] = 32'hffff_ffff;
               else          mem_b[END_A] = 32'hffff_ffff;
            end
            @(posedge clk);
            #1;
            c++;
         end
      end
      check("run_bounded", fin, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_time_limit: observed expired expected finish");
      $fatal(1, "time limit");
   end

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      num_words_a = 7'd4; num_words_b = 7'd4;
      sel = 0;
      for (int i = 0; i < MW; i++) gold[i] = 32'ha000_0000 + i;
      for (int i = 0; i < (1<<AW); i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      for (int i = 0; i < MW; i++) mem_a[i] = gold[i];
      mem_b[14'h3ffe] = gold[0];
      mem_b[14'h3fff] = gold[1];
      mem_b[0]        = gold[2];
      mem_b[1]        = gold[3];

      // End marker written at cycle 100, four matching words
      do_reset(0);
      run(100, 400, 0);
      check("s1_first_gold", first_gold, 102);
      check("s1_sweep_len",  done_cyc - first_gold, 5);
      check("s1_gold_cnt",   gold_cnt, 4);
      check("s1_mis_cnt",    mis_cnt, 0);
      check("s1_pass",       v_pass, 1);
      check("s1_err_cnt",    v_err_cnt, 0);
      check("s1_timeout",    v_timeout, 0);
      check("s1_fin_mem_re", v_mem_re, 0);
      check("s1_fin_gold_re", v_gold_re, 0);

      // Single mismatch on word 2
      mem_a[2] = 32'h1234_5678;
      gold[2]  = 32'h1234_5679;
      do_reset(0);
      run(-1, 100, 0);
      check("s2_mis_cnt",  mis_cnt, 1);
      check("s2_mis_addr", m_addr, 2);
      check("s2_mis_got",  m_got, 32'h1234_5678);
      check("s2_mis_exp",  m_exp, 32'h1234_5679);
      check("s2_err_cnt",  v_err_cnt, 1);
      check("s2_pass",     v_pass, 0);
      check("s2_done",     v_done, 1);
      gold[2]  = 32'ha000_0002;
      mem_a[2] = gold[2];

      // Zero words: no golden reads at all
      num_words_a = 7'd0;
      do_reset(0);
      run(-1, 100, 0);
      check("s3_gold_cnt", gold_cnt, 0);
      check("s3_done_cyc", done_cyc, 3);
      check("s3_pass",     v_pass, 1);
      check("s3_err_cnt",  v_err_cnt, 0);

      // Request above MAX_WORDS is clipped to 64; last word mismatched
      num_words_a = 7'd100;
      mem_a[63] = '0;
      do_reset(0);
      run(-1, 300, 0);
      check("s4_gold_cnt",  gold_cnt, 64);
      check("s4_sweep_len", done_cyc - first_gold, 65);
      check("s4_mis_cnt",   mis_cnt, 1);
      check("s4_mis_addr",  m_addr, 63);
      check("s4_mis_got",   m_got, 0);
      check("s4_mis_exp",   m_exp, 32'ha000_003f);
      check("s4_err_cnt",   v_err_cnt, 1);
      mem_a[63] = gold[63];

      // Reset during the third sweep cycle, while word 1 is mismatching in the compare stage
      num_words_a = 7'd4;
      mem_a[1] = '0;
      do_reset(0);
      run(-1, 100, 3);
      check("s5_stop_gold", gold_cnt, 3);
      rst_a = 1'b1;
      @(posedge clk);
      #1;
      check("s5_rst_mis_valid", v_mis_valid, 0);
      check("s5_rst_err_cnt",   v_err_cnt, 0);
      check("s5_rst_done",      v_done, 0);
      rst_a = 1'b0;
      #1;
      check("s5_poll_re",       v_mem_re, 1);
      check("s5_poll_addr",     v_mem_addr, END_A);
      check("s5_post_mis",      v_mis_valid, 0);
      mem_a[1] = gold[1];
      run(-1, 100, 0);
      check("s5_replay_gold",   gold_cnt, 4);
      check("s5_replay_mis",    mis_cnt, 0);
      check("s5_replay_err",    v_err_cnt, 0);
      check("s5_replay_pass",   v_pass, 1);

      // Watchdog expiry with wrapping sweep addresses
      do_reset(1);
      run(-1, 200, 0);
      check("s6_timeout_cyc", to_cyc, 50);
      check("s6_first_gold",  first_gold, 50);
      check("s6_gold_cnt",    gold_cnt, 4);
      check("s6_addr0",       addrs[0], 14'h3ffe);
      check("s6_addr1",       addrs[1], 14'h3fff);
      check("s6_addr2",       addrs[2], 14'h0000);
      check("s6_addr3",       addrs[3], 14'h0001);
      check("s6_err_cnt",     v_err_cnt, 0);
      check("s6_done_cyc",    done_cyc, 55);
      check("s6_pass",        v_pass, 0);

      // End marker seen in the same cycle the watchdog expires
      do_reset(1);
      run(48, 200, 0);
      check("s7_timeout_cyc", to_cyc, -1);
      check("s7_timeout",     v_timeout, 0);
      check("s7_first_gold",  first_gold, 50);
      check("s7_mis_cnt",     mis_cnt, 1);
      check("s7_mis_addr",    m_addr, 14'h3fff);
      check("s7_mis_got",     m_got, 32'hffff_ffff);
      check("s7_mis_exp",     m_exp, 32'ha000_0001);
      check("s7_err_cnt",     v_err_cnt, 1);
      check("s7_pass",        v_pass, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
